count_enable_ctrl: RTL

- Upstream stage of the b2_counter chain. Generates the chain's count-enable pulse (`ei`) under command control.
- Modes: free-running, single-step, burst of N pulses.
- A programmable prescaler spaces the pulses.
- Monitors the chain's final carry (`eu` of the last stage) so it can optionally stop on wrap-around.

---
 rtl/count_enable_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/count_enable_ctrl.sv
// count_enable_ctrl
//   Upstream stage of the b2_counter chain. It produces the chain's count
//   enable pulse (ei) under command control. There are three modes:
//   free-running (RUN), single step (STEP) and a burst of N pulses (BURST).
//   A prescaler spaces the pulses so that ei fires once every div+1 cycles.
//   The block can optionally stop when the last counter stage wraps.
//
// Ports
//   clock, reset   system clock; synchronous active-high reset
//   cmd_valid      command present
//   cmd_ready      command accepted when cmd_valid && cmd_ready at an edge
//   cmd_op         00 STOP, 01 RUN, 10 STEP, 11 BURST
//   cmd_div        prescaler divisor (sampled on accept)
//   cmd_len        burst pulse count (sampled on accept, BURST only)
//   cmd_wrap_stop  stop on chain wrap (sampled on accept)
//   wrap_in        carry out of the last counter stage (combinational from ei)
//   ei             registered count enable to the first counter stage
//   done           one-cycle pulse: STEP issued, burst complete or wrap stop
//   wrapped        one-cycle pulse: stopped because of a wrap
//   state          00 IDLE, 01 RUN, 10 BURST
module count_enable_ctrl #(
    parameter int DIV_W = 8,
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_wrap_stop,
    input  logic             wrap_in,
    output logic             ei,
    output logic             done,
    output logic             wrapped,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_BURST = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_STOP  = 2'b00,
        OP_RUN   = 2'b01,
        OP_STEP  = 2'b10,
        OP_BURST = 2'b11
    } op_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               ws_q, ws_d;
    logic               ei_d, done_d, wrapped_d;
    logic               accept;

    assign cmd_ready = ~reset;
    assign accept    = cmd_valid & cmd_ready;
    assign state     = state_q;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        div_d     = div_q;
        rem_d     = rem_q;
        ws_d      = ws_q;
        ei_d      = 1'b0;
        done_d    = 1'b0;
        wrapped_d = 1'b0;

        if (accept) begin
            // An accepted command always overrides the current mode,
            // including a prescaler tick or wrap stop due at this edge.
            case (op_t'(cmd_op))
                OP_STOP: begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end
                OP_RUN: begin
                    div_d   = cmd_div;
                    ws_d    = cmd_wrap_stop;
                    presc_d = '0;
                    rem_d   = '0;
                    state_d = S_RUN;
                end
                OP_STEP: begin
                    ei_d    = 1'b1;
                    done_d  = 1'b1;
                    rem_d   = '0;
                    state_d = S_IDLE;
                end
                OP_BURST: begin
                    if (cmd_len == '0) begin
                        // An empty burst completes at once and issues no pulse.
                        done_d  = 1'b1;
                        rem_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        div_d   = cmd_div;
                        ws_d    = cmd_wrap_stop;
                        presc_d = '0;
                        rem_d   = cmd_len;
                        state_d = S_BURST;
                    end
                end
                default: ;
            endcase
        end else if (state_q != S_IDLE) begin
            if (ws_q && ei && wrap_in) begin
                // The pulse that wrapped the chain has been delivered already.
                // Stop here so that no further pulse follows it.
                state_d   = S_IDLE;
                done_d    = 1'b1;
                wrapped_d = 1'b1;
                rem_d     = '0;
            end else if (presc_q == div_q) begin
                presc_d = '0;
                ei_d    = 1'b1;
                if (state_q == S_BURST) begin
                    rem_d = rem_q - LEN_W'(1);
                    // On the final pulse, done is raised in the same cycle as ei.
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            ws_q    <= 1'b0;
            ei      <= 1'b0;
            done    <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            ws_q    <= ws_d;
            ei      <= ei_d;
            done    <= done_d;
            wrapped <= wrapped_d;
        end
    end

endmodule
